// File: rtl/writeback_arbiter_if.sv
// Bundles the writeback arbiter's pipeline, long-latency, decode-query and
// register-file write-port signals into one interface.
interface writeback_arbiter_if #(
    parameter int DEPTH = 4
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             pipe_valid;
    logic [4:0]       pipe_register;
    logic [31:0]      pipe_data;
    logic             lu_valid;
    logic [4:0]       lu_register;
    logic [31:0]      lu_data;
    logic             lu_ready;
    logic [4:0]       query_register_1;
    logic [4:0]       query_register_2;
    logic             query_pending_1;
    logic             query_pending_2;
    logic [4:0]       write_register;
    logic [31:0]      write_data;
    logic             write_switch;
    logic [CNT_W-1:0] count;

    modport master (
        output pipe_valid, pipe_register, pipe_data,
        output lu_valid, lu_register, lu_data,
        input  lu_ready,
        output query_register_1, query_register_2,
        input  query_pending_1, query_pending_2,
        input  write_register, write_data, write_switch, count
    );

    modport slave (
        input  pipe_valid, pipe_register, pipe_data,
        input  lu_valid, lu_register, lu_data,
        output lu_ready,
        input  query_register_1, query_register_2,
        output query_pending_1, query_pending_2,
        output write_register, write_data, write_switch, count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges the never-stalling pipeline and a queued long-latency unit onto the
// single register-file write port, killing queued results made stale by newer pipeline writes.
module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    writeback_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       entry_register [DEPTH];
    logic [31:0]      entry_data     [DEPTH];
    logic [DEPTH-1:0] entry_kill;
    logic [DEPTH-1:0] occupied;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] occupancy_next;

    logic             out_switch;
    logic [4:0]       out_register;
    logic [31:0]      out_data;

    logic             accept;
    logic             push;
    logic             pipe_win;
    logic             pop;
    logic             push_killed;
    logic             pending_1;
    logic             pending_2;

    // Distance from head in ring order; kept in PTR_W bits so it wraps.
    function automatic logic [PTR_W-1:0] ring_offset(input logic [PTR_W-1:0] idx,
                                                     input logic [PTR_W-1:0] base);
        return idx - base;
    endfunction

    // Handshake, slot selection and WAW kill of a same-cycle push.
    always_comb begin
        accept      = ~reset & (occupancy < CNT_W'(DEPTH));
        push        = accept & bus.lu_valid & (bus.lu_register != 5'd0);
        pipe_win    = bus.pipe_valid & (bus.pipe_register != 5'd0);
        pop         = ~pipe_win & (occupancy != CNT_W'(0));
        push_killed = pipe_win & (bus.lu_register == bus.pipe_register);
    end

    // An entry is live when its ring distance from head is below the occupancy.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = ({1'b0, ring_offset(PTR_W'(i), head)} < occupancy);
        end
    end

    // Pending lookup: live non-killed queue entries plus the write in the output stage.
    always_comb begin
        pending_1 = out_switch & (out_register == bus.query_register_1);
        pending_2 = out_switch & (out_register == bus.query_register_2);
        for (int i = 0; i < DEPTH; i++) begin
            pending_1 = pending_1 | (occupied[i] & ~entry_kill[i] &
                                     (entry_register[i] == bus.query_register_1));
            pending_2 = pending_2 | (occupied[i] & ~entry_kill[i] &
                                     (entry_register[i] == bus.query_register_2));
        end
        pending_1 = pending_1 & (bus.query_register_1 != 5'd0);
        pending_2 = pending_2 & (bus.query_register_2 != 5'd0);
    end

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        case ({push, pop})
            2'b10:   occupancy_next = occupancy + CNT_W'(1);
            2'b01:   occupancy_next = occupancy - CNT_W'(1);
            default: occupancy_next = occupancy;
        endcase
    end

    // Queue storage, pointers and kill bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            occupancy  <= '0;
            entry_kill <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_register[i] <= 5'd0;
                entry_data[i]     <= 32'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_win && occupied[i] && (entry_register[i] == bus.pipe_register)) begin
                    entry_kill[i] <= 1'b1;
                end
            end
            if (push) begin
                entry_register[tail] <= bus.lu_register;
                entry_data[tail]     <= bus.lu_data;
                entry_kill[tail]     <= push_killed;
                tail                 <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            occupancy <= occupancy_next;
        end
    end

    // Output stage: the only source of the write port; holds register/data when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_switch   <= 1'b0;
            out_register <= 5'd0;
            out_data     <= 32'd0;
        end else if (pipe_win) begin
            out_switch   <= 1'b1;
            out_register <= bus.pipe_register;
            out_data     <= bus.pipe_data;
        end else if (pop) begin
            out_switch <= ~entry_kill[head];
            if (!entry_kill[head]) begin
                out_register <= entry_register[head];
                out_data     <= entry_data[head];
            end
        end else begin
            out_switch <= 1'b0;
        end
    end

    assign bus.lu_ready        = accept;
    assign bus.query_pending_1 = pending_1;
    assign bus.query_pending_2 = pending_2;
    assign bus.write_switch    = out_switch;
    assign bus.write_register  = out_register;
    assign bus.write_data      = out_data;
    assign bus.count           = occupancy;
endmodule
